// File: rtl/memory_responder_if.sv
// Request/response bus between a memory requester (master) and
// memory_responder (slave).
//
// Handshake (4-phase): the master raises memRead or memWrite with
// memAddress/memWriteData valid and holds the request high until it sees
// memReady. The slave samples the request once, then raises memReady when
// the access is done and keeps it high while the request stays high. The
// master then drops the request, and memReady falls one edge later. The
// master keeps the bus idle for at least one cycle before the next request.
// memError pulses for one cycle when a request is refused or abandoned.
interface memory_responder_if;
    logic [11:0] memAddress;
    logic [15:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [15:0] memReadData;
    logic        memReady;
    logic        memError;

    modport master (
        output memAddress, memWriteData, memRead, memWrite,
        input  memReadData, memReady, memError
    );

    modport slave (
        input  memAddress, memWriteData, memRead, memWrite,
        output memReadData, memReady, memError
    );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: 4096 x 16-bit word memory behind a 4-phase request bus.
// Each access is taken in IDLE, waits WAIT_CYCLES in WAIT, and is then
// performed and acknowledged in RESP.
// Optional build macro MEMORY_RESPONDER_ERR_EN: refuse read+write requests
// and abandon requests dropped during WAIT, flagging both on memError.
module memory_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] INIT_VALUE  = 16'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    memory_responder_if.slave         bus,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [11:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_op_write;
    logic [15:0] r_rdata;
    logic        r_ready;

    // Array content is not touched by reset; the initialiser only gives the
    // simulation-time value of words that were never written.
    logic [15:0] r_mem [0:4095] = '{default: INIT_VALUE};

    logic w_req;
    logic w_accept;
    logic w_abort;
    logic w_access;
    logic w_mem_we;

    assign w_req = bus.memRead | bus.memWrite;

`ifdef MEMORY_RESPONDER_ERR_EN
    logic r_err;

    // Both request lines high in IDLE is refused; a request that vanishes
    // while waiting abandons the access.
    assign w_accept = w_req && !(bus.memRead && bus.memWrite);
    assign w_abort  = (r_state == WAIT) && !w_req;
    assign bus.memError = r_err;

    // One-cycle error pulse for every refused or abandoned request edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= ((r_state == IDLE) && bus.memRead && bus.memWrite) || w_abort;
        end
    end
`else
    // Without error checking, read+write is taken as a write and a dropped
    // request in WAIT is simply ignored.
    assign w_accept     = w_req;
    assign w_abort      = 1'b0;
    assign bus.memError = 1'b0;
`endif

    // The access happens on the edge that leaves WAIT. The write enable is
    // derived from the state, so an asynchronous reset in WAIT blocks it.
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0) && !w_abort;
    assign w_mem_we = w_access && r_op_write;

    // Array write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Transaction FSM: latch request, count wait cycles, acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 12'd0;
            r_wdata    <= 16'd0;
            r_op_write <= 1'b0;
            r_rdata    <= 16'd0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.memAddress;
                        r_wdata    <= bus.memWriteData;
                        r_op_write <= bus.memWrite;
                        r_cnt      <= 4'(WAIT_CYCLES);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Writes leave the read data register untouched.
                        if (!r_op_write) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_ready <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (!w_req) begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.memReadData = r_rdata;
    assign bus.memReady    = r_ready;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder. Two instances (WAIT_CYCLES = 2 and 0)
// receive identical requests, so they share one memory model and differ
// only in their acknowledge latency.
module tb_memory_responder;

    localparam int          WA   = 2;
    localparam int          WB   = 0;
    localparam logic [15:0] INIT = 16'h5A5A;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        tb_rd    = 1'b0;
    logic        tb_wr    = 1'b0;
    logic [11:0] tb_addr  = 12'd0;
    logic [15:0] tb_wdata = 16'd0;

    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: sparse memory plus last read value.
    logic [15:0] ref_mem [int];
    logic [15:0] ref_rd = 16'd0;

    memory_responder_if bus_a ();
    memory_responder_if bus_b ();

    assign bus_a.memRead      = tb_rd;
    assign bus_a.memWrite     = tb_wr;
    assign bus_a.memAddress   = tb_addr;
    assign bus_a.memWriteData = tb_wdata;
    assign bus_b.memRead      = tb_rd;
    assign bus_b.memWrite     = tb_wr;
    assign bus_b.memAddress   = tb_addr;
    assign bus_b.memWriteData = tb_wdata;

    memory_responder #(.WAIT_CYCLES(WA), .INIT_VALUE(INIT)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_a.slave),
        .o_dbg_state (dbg_a)
    );

    memory_responder #(.WAIT_CYCLES(WB), .INIT_VALUE(INIT)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_b.slave),
        .o_dbg_state (dbg_b)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_rd(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return INIT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on both instances; called at posedge+#1.
    task automatic do_txn(input bit wr, input logic [11:0] a, input logic [15:0] d, input int hold);
        int lat_a;
        int lat_b;
        tb_rd    = !wr;
        tb_wr    = wr;
        tb_addr  = a;
        tb_wdata = d;
        step();                                   // request sampled here
        tb_addr  = 12'($urandom_range(0, 4095));  // must be ignored now
        tb_wdata = 16'($urandom);
        lat_a = 0;
        lat_b = 0;
        for (int k = 1; k <= 20 && (lat_a == 0 || lat_b == 0); k++) begin
            step();
            if (lat_a == 0 && bus_a.memReady) lat_a = k;
            if (lat_b == 0 && bus_b.memReady) lat_b = k;
        end
        check("latency_a", lat_a, WA + 1);
        check("latency_b", lat_b, WB + 1);
        for (int h = 0; h < hold; h++) begin
            tb_addr = 12'($urandom_range(0, 4095));
            step();
            check("hold_ready_a", bus_a.memReady, 1'b1);
            check("hold_ready_b", bus_b.memReady, 1'b1);
        end
        tb_rd = 1'b0;
        tb_wr = 1'b0;
        step();
        check("drop_ready_a", bus_a.memReady, 1'b0);
        check("drop_ready_b", bus_b.memReady, 1'b0);
        if (wr) ref_mem[int'(a)] = d;
        else    ref_rd = model_rd(a);
        check("rdata_a", bus_a.memReadData, ref_rd);
        check("rdata_b", bus_b.memReadData, ref_rd);
        check("err_a", bus_a.memError, 1'b0);
        step();                                   // mandatory idle cycle
        check("idle_rdata_a", bus_a.memReadData, ref_rd);
        check("idle_rdata_b", bus_b.memReadData, ref_rd);
    endtask

    initial begin
        logic [11:0] pool [4];
        pool[0] = 12'h0DC;
        pool[1] = 12'hFFF;
        pool[2] = 12'h010;
        pool[3] = 12'h0AB;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_a", bus_a.memReady, 1'b0);
        check("rst_ready_b", bus_b.memReady, 1'b0);
        check("rst_rdata_a", bus_a.memReadData, 16'd0);
        check("rst_rdata_b", bus_b.memReadData, 16'd0);
        check("rst_err_a", bus_a.memError, 1'b0);
        check("rst_state_a", dbg_a, 2'd0);
        rst = 1'b1;

        // Write then read back, latency check on both instances
        do_txn(1'b1, 12'h0DC, 16'hBEEF, 0);
        do_txn(1'b0, 12'h0DC, 16'h0000, 0);
        // Write elsewhere: read data must keep BEEF
        do_txn(1'b1, 12'h123, 16'h0001, 0);
        // Top address, then address zero is untouched
        do_txn(1'b1, 12'hFFF, 16'h1234, 0);
        do_txn(1'b0, 12'hFFF, 16'h0000, 0);
        do_txn(1'b0, 12'h000, 16'h0000, 0);
        // Hold the request 5 cycles past memReady
        do_txn(1'b0, 12'h0DC, 16'h0000, 5);

        // Reset during WAIT abandons a pending write
        do_txn(1'b1, 12'h010, 16'h1357, 0);
        tb_wr    = 1'b1;
        tb_addr  = 12'h010;
        tb_wdata = 16'hAAAA;
        step();
        rst = 1'b0;
        #1;
        check("wrst_ready_a", bus_a.memReady, 1'b0);
        check("wrst_ready_b", bus_b.memReady, 1'b0);
        check("wrst_rdata_a", bus_a.memReadData, 16'd0);
        check("wrst_rdata_b", bus_b.memReadData, 16'd0);
        tb_wr = 1'b0;
        ref_rd = 16'd0;
        step();
        step();
        rst = 1'b1;
        do_txn(1'b0, 12'h010, 16'h0000, 0);

        // Read and write both high for one cycle in IDLE
        tb_rd    = 1'b1;
        tb_wr    = 1'b1;
        tb_addr  = 12'h0AB;
        tb_wdata = 16'hC0DE;
        step();
`ifdef MEMORY_RESPONDER_ERR_EN
        check("both_err_a", bus_a.memError, 1'b1);
        check("both_err_b", bus_b.memError, 1'b1);
`else
        check("both_err_a", bus_a.memError, 1'b0);
        ref_mem[int'(12'h0AB)] = 16'hC0DE;
`endif
        tb_rd = 1'b0;
        tb_wr = 1'b0;
        step();
        check("both_err_end_a", bus_a.memError, 1'b0);
        repeat (5) step();
        check("both_ready_a", bus_a.memReady, 1'b0);
        check("both_ready_b", bus_b.memReady, 1'b0);
        do_txn(1'b0, 12'h0AB, 16'h0000, 0);

`ifdef MEMORY_RESPONDER_ERR_EN
        // Request dropped while waiting: error pulse, no write
        tb_wr    = 1'b1;
        tb_addr  = 12'h0AC;
        tb_wdata = 16'h7777;
        step();
        tb_wr = 1'b0;
        step();
        check("drop_err_a", bus_a.memError, 1'b1);
        check("drop_err_b", bus_b.memError, 1'b1);
        step();
        check("drop_err_end_a", bus_a.memError, 1'b0);
        repeat (4) step();
        check("drop_noready_a", bus_a.memReady, 1'b0);
        do_txn(1'b0, 12'h0AC, 16'h0000, 0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 24; i++) begin
            logic [11:0] a;
            int sel;
            sel = $urandom_range(0, 4);
            if (sel == 4) a = 12'($urandom_range(0, 4095));
            else          a = pool[sel];
            do_txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait cycles inserted before each access completes (legal range 0-15).
REQ-002 Parameter INIT_VALUE, default 16'd0, simulation-time content of every array word before any write.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 memAddress  input  12  word address of request.
REQ-006 memWriteData  input  16  write data.
REQ-007 memRead  input  1  read request, held high until memReady seen.
REQ-008 memWrite  input  1  write request, held high until memReady seen.
REQ-009 memReadData  output  16  registered read data.
REQ-010 memReady  output  1  completion, registered, 4-phase handshake.
REQ-011 memError  output  1  protocol-error pulse (present only per REQ-027).

Function
REQ-012 Storage SHALL be 4096 x 16-bit words, indexed by the full 12-bit address, with no address wrap or aliasing.
REQ-013 FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 IDLE: on an edge with memRead or memWrite high, SHALL latch address, write data and operation, load wait counter with WAIT_CYCLES, and go to WAIT.
REQ-015 WAIT: counter nonzero -> decrement and stay; counter zero -> perform access and go to RESP on that edge.
REQ-016 Access: read loads memReadData from array[latched address]; write stores latched data into array[latched address]; write SHALL NOT change memReadData.
REQ-017 Latency: request sampled at edge N -> memReady high after edge N+WAIT_CYCLES+1; WAIT_CYCLES=0 gives exactly one cycle.
REQ-018 RESP: memReady SHALL stay high while the request is high; first edge with both memRead and memWrite low -> IDLE, memReady low after that edge.
REQ-019 Requests are single-outstanding; request-line or address/data changes after the latch edge SHALL be ignored until return to IDLE.
REQ-020 A new request SHALL be accepted no earlier than the edge after returning to IDLE (minimum one idle cycle between transactions).
REQ-021 memReadData SHALL hold its last read value across writes and idle cycles until the next read completes.
REQ-022 Read of a never-written word SHALL return INIT_VALUE.

Reset
REQ-023 rst low SHALL immediately force state IDLE, memReady 0, memReadData 16'd0, wait counter 0, memError 0, latched request cleared.
REQ-024 Array contents SHALL NOT be cleared by reset.
REQ-025 Reset during WAIT SHALL abandon the pending access; a pending write SHALL NOT reach the array.
REQ-026 After rst rises, first request SHALL be accepted on the first rising edge with a request high.

Configuration
REQ-027 Macro MEMORY_RESPONDER_ERR_EN defined: memRead and memWrite both high in IDLE SHALL be refused (stay IDLE, no access) and memError SHALL pulse high for exactly one cycle per such edge; request dropped in WAIT (both low) SHALL pulse memError once, abandon the access and return to IDLE.
REQ-028 Macro undefined: memError SHALL be tied 0; both-high in IDLE SHALL be treated as a write; request dropped in WAIT SHALL be ignored and the access completes normally, RESP exiting on the next edge since the request is already low.

Verification
REQ-029 WAIT_CYCLES=2; write 16'hBEEF to 12'h0DC, then read 12'h0DC -> memReady high 3 cycles after each request edge, memReadData 16'hBEEF.
REQ-030 WAIT_CYCLES=0; read 12'hFFF after writing 16'h1234 there -> memReady after one edge, memReadData 16'h1234; read 12'h000 returns INIT_VALUE (no wrap).
REQ-031 Read 16'hBEEF, then write 16'h0001 elsewhere -> memReadData stays 16'hBEEF through write and idle.
REQ-032 Start write of 16'hAAAA to 12'h010, assert rst low in WAIT -> outputs reset at once; later read of 12'h010 returns prior content, not 16'hAAAA.
REQ-033 Hold request high 5 cycles after memReady -> memReady stays high all 5 cycles, drops one edge after request drops; address change during RESP has no effect.
REQ-034 With MEMORY_RESPONDER_ERR_EN: memRead=memWrite=1 for one cycle in IDLE -> memError one-cycle pulse, no memReady, array unchanged; without macro: same stimulus performs a write.
